// File: rtl/memory_controller.sv
// Byte-wide RAM/IO port sequencer shared by instruction fetch and the load/store buffer.
// Splits requests into byte accesses, reassembles little-endian reads, arbitrates round-robin.
module memory_controller (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_signal,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        if_signal,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_signal,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_din,
    output logic [31:0] lsb_dout,
    output logic        lsb_done
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_len;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic        r_last_lsb;

    logic        w_io_blocked;
    logic        w_lsb_req;
    logic        w_any_req;
    logic        w_grant_ok;
    logic        w_pick_lsb;
    logic [2:0]  w_lsb_n;
    logic [2:0]  w_next_cnt;
    logic [31:0] w_next_addr;
    logic        w_last_present;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_rbuf_next;
    logic [7:0]  w_wr_byte;

    // A store to the UART window cannot start while its output buffer is full.
    assign w_io_blocked   = lsb_wr && (lsb_addr[17:16] == 2'b11) && io_buffer_full;
    assign w_lsb_req      = lsb_signal && !w_io_blocked;
    assign w_any_req      = if_signal || w_lsb_req;
    assign w_grant_ok     = !if_done && !lsb_done && !clear_signal;
    assign w_pick_lsb     = w_lsb_req && (!if_signal || !r_last_lsb);
    assign w_lsb_n        = (lsb_len == 2'b00) ? 3'd1 : ((lsb_len == 2'b01) ? 3'd2 : 3'd4);
    assign w_next_cnt     = r_cnt + 3'd1;
    assign w_next_addr    = r_addr + 32'(w_next_cnt);
    assign w_last_present = (w_next_cnt == r_len);
    assign w_cap_idx      = 2'(r_cnt - 3'd1);

    // Read data arriving now belongs to the byte presented two edges earlier.
    always_comb begin
        w_rbuf_next = r_buf;
        if (r_cnt != 3'd0) begin
            case (w_cap_idx)
                2'd0: w_rbuf_next[7:0]   = mem_din;
                2'd1: w_rbuf_next[15:8]  = mem_din;
                2'd2: w_rbuf_next[23:16] = mem_din;
                2'd3: w_rbuf_next[31:24] = mem_din;
            endcase
        end
    end

    always_comb begin
        w_wr_byte = r_wdata[7:0];
        case (w_next_cnt[1:0])
            2'd0: w_wr_byte = r_wdata[7:0];
            2'd1: w_wr_byte = r_wdata[15:8];
            2'd2: w_wr_byte = r_wdata[23:16];
            2'd3: w_wr_byte = r_wdata[31:24];
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_len      <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_buf      <= 32'd0;
            r_last_lsb <= 1'b1;
            mem_a      <= 32'd0;
            mem_dout   <= 8'd0;
            mem_wr     <= 1'b0;
            if_done    <= 1'b0;
            if_data    <= 32'd0;
            lsb_done   <= 1'b0;
            lsb_dout   <= 32'd0;
        end else if (rdy_in) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_ok && w_any_req) begin
                        r_cnt <= 3'd0;
                        r_buf <= 32'd0;
                        if (w_pick_lsb) begin
                            r_last_lsb <= 1'b1;
                            r_addr     <= lsb_addr;
                            r_len      <= w_lsb_n;
                            r_wdata    <= lsb_din;
                            mem_a      <= lsb_addr;
                            if (lsb_wr) begin
                                r_state  <= STORE;
                                mem_dout <= lsb_din[7:0];
                                mem_wr   <= 1'b1;
                            end else begin
                                r_state <= LOAD;
                                mem_wr  <= 1'b0;
                            end
                        end else begin
                            r_last_lsb <= 1'b0;
                            r_addr     <= if_addr;
                            r_len      <= 3'd4;
                            mem_a      <= if_addr;
                            mem_wr     <= 1'b0;
                            r_state    <= FETCH;
                        end
                    end
                end
                FETCH, LOAD: begin
                    if (clear_signal) begin
                        r_state <= IDLE;
                        r_cnt   <= 3'd0;
                        mem_a   <= 32'd0;
                    end else begin
                        r_buf <= w_rbuf_next;
                        if (r_cnt == r_len) begin
                            r_state <= IDLE;
                            r_cnt   <= 3'd0;
                            if (r_state == FETCH) begin
                                if_done <= 1'b1;
                                if_data <= w_rbuf_next;
                            end else begin
                                lsb_done <= 1'b1;
                                lsb_dout <= w_rbuf_next;
                            end
                        end else begin
                            r_cnt <= w_next_cnt;
                            // Park the address after the last byte so no stray IO read fires.
                            mem_a <= w_last_present ? 32'd0 : w_next_addr;
                        end
                    end
                end
                STORE: begin
                    if (w_last_present) begin
                        r_state  <= IDLE;
                        r_cnt    <= 3'd0;
                        mem_wr   <= 1'b0;
                        mem_a    <= 32'd0;
                        lsb_done <= 1'b1;
                    end else begin
                        r_cnt    <= w_next_cnt;
                        mem_a    <= w_next_addr;
                        mem_dout <= w_wr_byte;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a one-cycle-latency byte RAM model.
module tb_memory_controller;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_signal;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_signal;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_signal;
    logic        lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_din;
    logic [31:0] lsb_dout;
    logic        lsb_done;

    int total;
    int bad;

    logic [7:0] ram [0:65535];
    logic [7:0] ram_q;

    memory_controller dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_signal   (clear_signal),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .if_signal      (if_signal),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .lsb_signal     (lsb_signal),
        .lsb_wr         (lsb_wr),
        .lsb_len        (lsb_len),
        .lsb_addr       (lsb_addr),
        .lsb_din        (lsb_din),
        .lsb_dout       (lsb_dout),
        .lsb_done       (lsb_done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // RAM: address latched at one edge, data sampled by the DUT at the next.
    always @(posedge clk_in) begin
        if (rst_in) begin
            ram[16'h1000] <= 8'h13;
            ram[16'h1001] <= 8'h05;
            ram[16'h1002] <= 8'h00;
            ram[16'h1003] <= 8'h00;
            ram[16'h0020] <= 8'hFE;
            ram[16'h0021] <= 8'hFF;
            ram[16'hFFFF] <= 8'h77;
        end else if (rdy_in) begin
            ram_q <= ram[mem_a[15:0]];
            if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        end
    end
    assign mem_din = ram_q;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0; io_buffer_full = 1'b0;
        if_signal = 1'b0; if_addr = 32'd0;
        lsb_signal = 1'b0; lsb_wr = 1'b0; lsb_len = 2'b00; lsb_addr = 32'd0; lsb_din = 32'd0;
        repeat (3) step();
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_lsb_done", 32'(lsb_done), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_lsb_dout", lsb_dout, 32'd0);
        rst_in = 1'b0;

        // Fetch of one word
        if_signal = 1'b1; if_addr = 32'h0000_1000;
        step(); chk("fetch_a0", mem_a, 32'h1000); chk("fetch_wr", 32'(mem_wr), 32'd0);
        step(); chk("fetch_a1", mem_a, 32'h1001);
        step(); chk("fetch_a2", mem_a, 32'h1002);
        step(); chk("fetch_a3", mem_a, 32'h1003);
        step(); chk("fetch_park", mem_a, 32'd0); chk("fetch_early_done", 32'(if_done), 32'd0);
        step(); chk("fetch_done", 32'(if_done), 32'd1); chk("fetch_data", if_data, 32'h0000_0513);
        if_signal = 1'b0;
        step(); chk("fetch_done_pulse", 32'(if_done), 32'd0);

        // Two-byte load
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b01; lsb_addr = 32'h20;
        step(); chk("ld2_a0", mem_a, 32'h20);
        step(); chk("ld2_a1", mem_a, 32'h21);
        step(); chk("ld2_park", mem_a, 32'd0); chk("ld2_early_done", 32'(lsb_done), 32'd0);
        step(); chk("ld2_done", 32'(lsb_done), 32'd1); chk("ld2_data", lsb_dout, 32'h0000_FFFE);
        lsb_signal = 1'b0;
        step();

        // One-byte load
        lsb_signal = 1'b1; lsb_len = 2'b00; lsb_addr = 32'h21;
        step(); chk("ld1_a0", mem_a, 32'h21);
        step(); chk("ld1_early_done", 32'(lsb_done), 32'd0);
        step(); chk("ld1_done", 32'(lsb_done), 32'd1); chk("ld1_data", lsb_dout, 32'h0000_00FF);
        lsb_signal = 1'b0;
        step();

        // Four-byte store
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b11; lsb_addr = 32'h100; lsb_din = 32'hDEAD_BEEF;
        step(); chk("st_a0", mem_a, 32'h100); chk("st_d0", 32'(mem_dout), 32'hEF); chk("st_wr0", 32'(mem_wr), 32'd1);
        step(); chk("st_a1", mem_a, 32'h101); chk("st_d1", 32'(mem_dout), 32'hBE);
        step(); chk("st_a2", mem_a, 32'h102); chk("st_d2", 32'(mem_dout), 32'hAD);
        step(); chk("st_a3", mem_a, 32'h103); chk("st_d3", 32'(mem_dout), 32'hDE);
        chk("st_wr3", 32'(mem_wr), 32'd1); chk("st_early_done", 32'(lsb_done), 32'd0);
        step(); chk("st_wr_end", 32'(mem_wr), 32'd0); chk("st_park", mem_a, 32'd0); chk("st_done", 32'(lsb_done), 32'd1);
        chk("st_ram", {ram[16'h103], ram[16'h102], ram[16'h101], ram[16'h100]}, 32'hDEAD_BEEF);
        lsb_signal = 1'b0;
        step();

        // Asynchronous reset in the middle of a store
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b11; lsb_addr = 32'h200; lsb_din = 32'h1122_3344;
        step(); chk("rst_st_wr", 32'(mem_wr), 32'd1);
        step();
        #2 rst_in = 1'b1;
        #1;
        chk("arst_mem_wr", 32'(mem_wr), 32'd0);
        chk("arst_mem_a", mem_a, 32'd0);
        chk("arst_mem_dout", 32'(mem_dout), 32'd0);
        chk("arst_if_data", if_data, 32'd0);
        chk("arst_lsb_dout", lsb_dout, 32'd0);
        lsb_signal = 1'b0; lsb_wr = 1'b0;
        step();
        rst_in = 1'b0;

        // Simultaneous requests: fetch first, turnaround cycle, then LSB
        if_signal = 1'b1; if_addr = 32'h1000;
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b00; lsb_addr = 32'h20;
        step(); chk("tie_fetch_first", mem_a, 32'h1000);
        repeat (4) step();
        step(); chk("tie_if_done", 32'(if_done), 32'd1); chk("tie_if_data", if_data, 32'h0000_0513);
        step(); chk("tie_turnaround", mem_a, 32'd0); chk("tie_no_done", 32'(if_done), 32'd0);
        step(); chk("tie_lsb_second", mem_a, 32'h20);
        if_signal = 1'b0;
        step(); chk("tie_lsb_park", mem_a, 32'd0);
        step(); chk("tie_lsb_done", 32'(lsb_done), 32'd1); chk("tie_lsb_data", lsb_dout, 32'h0000_00FE);
        lsb_signal = 1'b0;
        step();

        // IO store held off by a full UART buffer while a fetch proceeds
        io_buffer_full = 1'b1;
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b00; lsb_addr = 32'h0003_0000; lsb_din = 32'h0000_005A;
        if_signal = 1'b1; if_addr = 32'h1000;
        step(); chk("io_fetch_a", mem_a, 32'h1000); chk("io_fetch_wr", 32'(mem_wr), 32'd0);
        repeat (4) step();
        step(); chk("io_fetch_done", 32'(if_done), 32'd1);
        if_signal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); chk("io_store_wait", 32'(mem_wr), 32'd0);
        end
        io_buffer_full = 1'b0;
        step(); chk("io_st_a", mem_a, 32'h0003_0000); chk("io_st_wr", 32'(mem_wr), 32'd1); chk("io_st_d", 32'(mem_dout), 32'h5A);
        step(); chk("io_st_done", 32'(lsb_done), 32'd1); chk("io_st_wr_end", 32'(mem_wr), 32'd0);
        chk("io_dout_hold", 32'(mem_dout), 32'h5A);
        lsb_signal = 1'b0; lsb_wr = 1'b0;
        step();

        // Flush two cycles into a four-byte load
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b11; lsb_addr = 32'h1000;
        step(); chk("fl_ld_a0", mem_a, 32'h1000);
        step(); chk("fl_ld_a1", mem_a, 32'h1001);
        clear_signal = 1'b1; lsb_signal = 1'b0;
        step(); chk("fl_ld_park", mem_a, 32'd0); chk("fl_ld_nodone", 32'(lsb_done), 32'd0);
        clear_signal = 1'b0;
        step(); chk("fl_ld_nodone2", 32'(lsb_done), 32'd0); chk("fl_ld_hold", lsb_dout, 32'h0000_00FE);

        // Flush during a store (len 10 acts as four bytes)
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = 2'b10; lsb_addr = 32'h300; lsb_din = 32'hA1B2_C3D4;
        step(); chk("fl_st_a0", mem_a, 32'h300); chk("fl_st_d0", 32'(mem_dout), 32'hD4);
        clear_signal = 1'b1;
        step(); chk("fl_st_a1", mem_a, 32'h301); chk("fl_st_d1", 32'(mem_dout), 32'hC3);
        step(); chk("fl_st_a2", mem_a, 32'h302); chk("fl_st_d2", 32'(mem_dout), 32'hB2);
        clear_signal = 1'b0;
        step(); chk("fl_st_a3", mem_a, 32'h303); chk("fl_st_d3", 32'(mem_dout), 32'hA1);
        step(); chk("fl_st_done", 32'(lsb_done), 32'd1); chk("fl_st_wr_end", 32'(mem_wr), 32'd0);
        lsb_signal = 1'b0; lsb_wr = 1'b0;
        step();

        // Flush in IDLE blocks the grant; rdy_in low freezes a fetch and a done pulse
        clear_signal = 1'b1; if_signal = 1'b1; if_addr = 32'h1000;
        step(); chk("idle_clear_nogrant", mem_a, 32'd0);
        clear_signal = 1'b0;
        step(); chk("rdy_a0", mem_a, 32'h1000);
        step(); chk("rdy_a1", mem_a, 32'h1001);
        rdy_in = 1'b0;
        step(); chk("rdy_hold0", mem_a, 32'h1001);
        step(); chk("rdy_hold1", mem_a, 32'h1001);
        rdy_in = 1'b1;
        step(); chk("rdy_a2", mem_a, 32'h1002);
        step(); chk("rdy_a3", mem_a, 32'h1003);
        step(); chk("rdy_park", mem_a, 32'd0);
        step(); chk("rdy_done", 32'(if_done), 32'd1); chk("rdy_data", if_data, 32'h0000_0513);
        if_signal = 1'b0; rdy_in = 1'b0;
        step(); chk("rdy_pulse_hold", 32'(if_done), 32'd1);
        rdy_in = 1'b1;
        step(); chk("rdy_pulse_end", 32'(if_done), 32'd0);

        // Address wraps from 0xFFFFFFFF to 0
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b01; lsb_addr = 32'hFFFF_FFFF;
        step(); chk("wrap_a0", mem_a, 32'hFFFF_FFFF);
        step(); chk("wrap_a1", mem_a, 32'd0);
        step();
        step(); chk("wrap_done", 32'(lsb_done), 32'd1); chk("wrap_data", lsb_dout, 32'h0000_5A77);
        lsb_signal = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
